// File: rtl/peripheral_disp_scan.sv
// peripheral_disp_scan: time-multiplexed scan controller for an N-digit common-anode 7-seg display
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data  register write port (0..N_DIGITS-1 digit {ext,value}, N_DIGITS ctrl {enable},
//                          N_DIGITS+1 blink mask)
//   rd_addr/rd_data     registered readback, 1-cycle latency, unmapped reads return 0
//   DIG_D/DIG_EXT       nibble and extended flag for the downstream 7-seg decoder
//   AN                  active-low anode enables, at most one bit low
// Optional feature: define DISP_BLINK_EN for the blink mask register and frame-based blinking.
module peripheral_disp_scan #(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_DIV    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [3:0]          rd_addr,
    output logic [7:0]          rd_data,
    output logic [3:0]          DIG_D,
    output logic                DIG_EXT,
    output logic [N_DIGITS-1:0] AN
);
    localparam int CW = $clog2(PRESCALE + BLANK_CYCLES + 1);
    localparam int IW = $clog2(N_DIGITS);

    if (N_DIGITS < 2 || N_DIGITS > 8 || PRESCALE < 2 || BLANK_CYCLES < 0 || BLINK_DIV < 1) begin : g_bad_params
        $error("peripheral_disp_scan: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [IW-1:0] r_idx, w_idx_next;
    logic          r_en;
    logic [4:0]    r_dig [N_DIGITS];
    logic [7:0]    w_rd;
    logic          w_last, w_wrap, w_hide;
    logic          w_unused;

    assign w_unused = &{1'b0, wr_data[7:5]};
    assign w_last   = (r_idx == IW'(N_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) r_dig[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < N_DIGITS; i++) if (wr_addr == 4'(i)) r_dig[i] <= wr_data[4:0];
            if (wr_addr == 4'(N_DIGITS)) r_en <= wr_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            DIG_D   <= '0;
            DIG_EXT <= 1'b0;
            rd_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            // sourced from the upcoming index so the decoder already holds the new digit during BLANK
            {DIG_EXT, DIG_D} <= r_dig[w_idx_next];
            rd_data <= w_rd;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_wrap       = 1'b0;
        if (!r_en) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
        end else if (r_state == IDLE) begin
            w_state_next = SHOW;
        end else if (r_state == SHOW) begin
            if (r_cnt == CW'(PRESCALE - 1)) begin
                w_cnt_next   = '0;
                w_idx_next   = w_last ? '0 : r_idx + 1'b1;
                w_wrap       = w_last;
                w_state_next = (BLANK_CYCLES > 0) ? BLANK : SHOW;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end else begin
            w_cnt_next   = (r_cnt == CW'(BLANK_CYCLES - 1)) ? '0 : r_cnt + 1'b1;
            w_state_next = (r_cnt == CW'(BLANK_CYCLES - 1)) ? SHOW : BLANK;
        end
    end

    always_comb begin
        AN = '1;
        if (r_state == SHOW && !w_hide) AN[r_idx] = 1'b0;
    end

`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [N_DIGITS-1:0] r_mask;
    logic [BW-1:0]       r_frame;
    logic                r_phase;
    logic                w_div_end;

    assign w_div_end = (r_frame == BW'(BLINK_DIV - 1));
    assign w_hide    = r_phase && r_mask[r_idx];

    always_ff @(posedge clk) begin
        if (rst) r_mask <= '0;
        else if (wr_en && wr_addr == 4'(N_DIGITS + 1)) r_mask <= wr_data[N_DIGITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || !r_en) begin
            r_frame <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_frame <= w_div_end ? '0 : r_frame + 1'b1;
            r_phase <= r_phase ^ w_div_end;
        end
    end
`else
    assign w_hide = 1'b0;
`endif

    always_comb begin
        w_rd = 8'h00;
        for (int i = 0; i < N_DIGITS; i++) if (rd_addr == 4'(i)) w_rd = {3'b000, r_dig[i]};
        if (rd_addr == 4'(N_DIGITS)) w_rd = {7'b0, r_en};
`ifdef DISP_BLINK_EN
        if (rd_addr == 4'(N_DIGITS + 1)) w_rd = 8'(r_mask);
`endif
    end
endmodule

// File: tb/tb_peripheral_disp_scan.sv
// tb_peripheral_disp_scan: checks the scan controller against a time-based display model
`timescale 1ns/1ps
module tb_peripheral_disp_scan;
    localparam int N  = 4;
    localparam int P  = 4;
    localparam int BL = 2;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] rd_addr = '0;
    logic [7:0] rd_a, rd_b;
    logic [3:0] d_a, d_b, an_a, an_b;
    logic       ext_a, ext_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    peripheral_disp_scan #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(BL), .BLINK_DIV(BD)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_a), .DIG_D(d_a), .DIG_EXT(ext_a), .AN(an_a));

    peripheral_disp_scan #(.N_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(0), .BLINK_DIV(BD)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_b), .DIG_D(d_b), .DIG_EXT(ext_b), .AN(an_b));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: register contents plus a per-instance count of cycles since the scan started
    logic [4:0]   m_reg [N];
    logic [4:0]   m_reg_d [N];
    logic         m_en = 1'b0;
    logic         started = 1'b0;
    logic [N-1:0] m_mask = '0;
    logic [7:0]   m_rd = '0;
    int           t_a = -1;
    int           t_b = -1;

    function automatic logic [7:0] rdmap(input logic [3:0] a);
        if (a < N) return {3'b000, m_reg[a[1:0]]};
        if (a == N) return {7'b0, m_en};
`ifdef DISP_BLINK_EN
        if (a == N + 1) return {4'b0, m_mask};
`endif
        return 8'h00;
    endfunction

    function automatic logic [3:0] exp_an(input int t, input int b);
        int slot, p, dg;
        if (t < 0) return 4'hF;
        slot = P + b;
        p = t % (N * slot);
        if (p % slot >= P) return 4'hF;
        dg = p / slot;
`ifdef DISP_BLINK_EN
        if (((t / (N * slot)) / BD) % 2 == 1 && m_mask[dg]) return 4'hF;
`endif
        return ~(4'(1) << dg);
    endfunction

    function automatic int exp_idx(input int t, input int b);
        if (t < 0) return 0;
        return (((t % (N * (P + b))) + b) / (P + b)) % N;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started <= 1'b1;
            m_en    <= 1'b0;
            m_mask  <= '0;
            m_rd    <= '0;
            t_a     <= -1;
            t_b     <= -1;
            for (int i = 0; i < N; i++) begin
                m_reg[i]   <= '0;
                m_reg_d[i] <= '0;
            end
        end else begin
            t_a  <= m_en ? t_a + 1 : -1;
            t_b  <= m_en ? t_b + 1 : -1;
            m_rd <= rdmap(rd_addr);
            for (int i = 0; i < N; i++) m_reg_d[i] <= m_reg[i];
            if (wr_en && wr_addr < N) m_reg[wr_addr[1:0]] <= wr_data[4:0];
            if (wr_en && wr_addr == N) m_en <= wr_data[0];
`ifdef DISP_BLINK_EN
            if (wr_en && wr_addr == N + 1) m_mask <= wr_data[N-1:0];
`endif
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("an_a", an_a, exp_an(t_a, BL));
            check("dig_a", {ext_a, d_a}, m_reg_d[exp_idx(t_a, BL)]);
            check("rd_a", rd_a, m_rd);
            check("an_b", an_b, exp_an(t_b, 0));
            check("dig_b", {ext_b, d_b}, m_reg_d[exp_idx(t_b, 0)]);
            check("rd_b", rd_b, m_rd);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] v, input int lim, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            ok = (an_a == v);
        end
        check(nm, 32'(ok), 1);
    endtask

    logic [3:0] seq [24] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF,
                             4'hD, 4'hD, 4'hD, 4'hD, 4'hF, 4'hF,
                             4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF,
                             4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF};
    logic [5:0] lit0, lit1;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_an", an_a, 4'hF);
        check("rst_d", d_a, 4'h0);
        check("rst_ext", ext_a, 1'b0);
        check("rst_rd", rd_a, 8'h00);
        repeat (100) @(negedge clk);
        check("idle_an", an_a, 4'hF);
        check("idle_d", d_a, 4'h0);
        wr(0, 8'h01);
        wr(1, 8'h02);
        wr(2, 8'h03);
        wr(3, 8'hE4);
        rd_addr = 3;
        @(negedge clk);
        check("rd_upper_ignored", rd_a, 8'h04);
        rd_addr = 2;
        @(negedge clk);
        check("rd_dig2", rd_a, 8'h03);
        wr(4, 8'h01);
        check("pre_start_an", an_a, 4'hF);
        for (int j = 0; j < 48; j++) begin
            @(negedge clk);
            check("scan_an", an_a, seq[j % 24]);
            if (an_a != 4'hF) check("scan_dig", d_a, 32'((j % 24) / 6 + 1));
        end
        wr(2, 8'h1C);
        @(negedge clk);
        wait_an(4'hB, 30, "wait_dig2");
        check("ext_d", d_a, 4'hC);
        check("ext_flag", ext_a, 1'b1);
        wait_an(4'hF, 30, "wait_blank");
        wait_an(4'hE, 30, "wait_dig0");
        wr(0, 8'h09);
        check("live_old", d_a, 4'h1);
        check("live_an1", an_a, 4'hE);
        @(negedge clk);
        check("live_new", d_a, 4'h9);
        @(negedge clk);
        check("live_an3", an_a, 4'hE);
        @(negedge clk);
        check("live_slot_end", an_a, 4'hF);
        wr(4, 8'h00);
        check("dis_an0", an_a, 4'hF);
        @(negedge clk);
        check("dis_idle", an_a, 4'hF);
        rd_addr = 4;
        @(negedge clk);
        check("dis_rd_ctrl", rd_a, 8'h00);
        wr(4, 8'h01);
        check("reen_an0", an_a, 4'hF);
        @(negedge clk);
        check("reen_first", an_a, 4'hE);
        repeat (20) begin
            @(negedge clk);
            check("noblank_onehot", $countones(an_b), 3);
        end
        rd_addr = 1;
        wr(1, 8'h07);
        check("same_cycle_old", rd_a, 8'h02);
        @(negedge clk);
        check("same_cycle_new", rd_a, 8'h07);
        wr(9, 8'hFF);
        rd_addr = 9;
        @(negedge clk);
        check("unmapped_rd", rd_a, 8'h00);
        rd_addr = 4;
        @(negedge clk);
        check("ctrl_rd", rd_a, 8'h01);
        wr(5, 8'h02);
        rd_addr = 5;
        @(negedge clk);
`ifdef DISP_BLINK_EN
        check("mask_rd", rd_a, 8'h02);
`else
        check("mask_rd", rd_a, 8'h00);
`endif
        wr(4, 8'h00);
        wr(4, 8'h01);
        lit0 = '0;
        lit1 = '0;
        for (int j = 0; j < 6 * 24; j++) begin
            @(negedge clk);
            if (!an_a[0]) lit0[j / 24] = 1'b1;
            if (!an_a[1]) lit1[j / 24] = 1'b1;
        end
        check("blink_dig0", lit0, 6'b111111);
`ifdef DISP_BLINK_EN
        check("blink_dig1", lit1, 6'b110011);
`else
        check("blink_dig1", lit1, 6'b111111);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_an", an_a, 4'hF);
        check("mid_rst_an_b", an_b, 4'hF);
        check("mid_rst_d", d_a, 4'h0);
        check("mid_rst_ext", ext_a, 1'b0);
        check("mid_rst_rd", rd_a, 8'h00);
        rd_addr = 4;
        repeat (10) @(negedge clk);
        check("post_rst_ctrl", rd_a, 8'h00);
        check("post_rst_an", an_a, 4'hF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
